// File: rtl/mem_scan_arbiter_if.sv
// Bus bundle between mem_scan_arbiter and its environment: control, host port and memory port.
// The slave modport is the arbiter's view; master is the driving side.
interface mem_scan_arbiter_if;
  logic        i_start;
  logic        i_abort;
  logic        i_host_req;
  logic [15:0] i_host_addr;
  logic        o_host_gnt;
  logic        o_host_rvalid;
  logic [7:0]  o_host_rdata;
  logic [15:0] o_mem_addr;
  logic        o_mem_en;
  logic [7:0]  i_mem_data;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_err_count;
  logic        o_first_err_valid;
  logic [15:0] o_first_err_addr;

  modport slave (
    input  i_start,
    input  i_abort,
    input  i_host_req,
    input  i_host_addr,
    input  i_mem_data,
    output o_host_gnt,
    output o_host_rvalid,
    output o_host_rdata,
    output o_mem_addr,
    output o_mem_en,
    output o_busy,
    output o_done,
    output o_err_count,
    output o_first_err_valid,
    output o_first_err_addr
  );

  modport master (
    output i_start,
    output i_abort,
    output i_host_req,
    output i_host_addr,
    output i_mem_data,
    input  o_host_gnt,
    input  o_host_rvalid,
    input  o_host_rdata,
    input  o_mem_addr,
    input  o_mem_en,
    input  o_busy,
    input  o_done,
    input  o_err_count,
    input  o_first_err_valid,
    input  o_first_err_addr
  );
endinterface

// File: rtl/mem_scan_arbiter.sv
// Shares the memory read port between host reads (always first) and a background scan that
// checks every byte against an address-derived pattern and records errors.
module mem_scan_arbiter #(
  parameter int unsigned DEPTH  = 5120,
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  SEED   = 8'hA5
) (
  input logic               i_clk,
  input logic               i_rst_n,
  mem_scan_arbiter_if.slave bus
);

  localparam logic [15:0] LastAddr = 16'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic        aborted_q, aborted_d;
  logic [15:0] err_count_q, err_count_d;
  logic        first_err_valid_q, first_err_valid_d;
  logic [15:0] first_err_addr_q, first_err_addr_d;
  logic [15:0] last_addr_q;
  logic        host_rvalid_q;
  logic [7:0]  host_rdata_q;
  logic        done;

  // Tag pipe: one entry per cycle, aligned with the memory read latency.
  logic [RD_LAT-1:0] tag_vld_q;
  logic [RD_LAT-1:0] tag_host_q;
  logic [15:0]       tag_addr_q [RD_LAT];

  logic        issue_host, issue_scan, issue_en;
  logic [15:0] issue_addr;
  logic        tag_out_vld, tag_out_host;
  logic [15:0] tag_out_addr;
  logic [7:0]  exp_byte;
  logic        mismatch, scan_in_pipe;

  // Host is gated by reset so every output reads 0 while reset is asserted.
  always_comb begin
    issue_host = bus.i_host_req & i_rst_n;
    issue_scan = ~bus.i_host_req & (state_q == StScan);
    issue_en   = issue_host | issue_scan;
    issue_addr = issue_host ? bus.i_host_addr : ptr_q;
  end

  assign tag_out_vld  = tag_vld_q[RD_LAT-1];
  assign tag_out_host = tag_host_q[RD_LAT-1];
  assign tag_out_addr = tag_addr_q[RD_LAT-1];
  assign exp_byte     = tag_out_addr[7:0] ^ tag_out_addr[15:8] ^ SEED;
  assign mismatch     = tag_out_vld & ~tag_out_host & (bus.i_mem_data != exp_byte);
  assign scan_in_pipe = |(tag_vld_q & ~tag_host_q);

  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    aborted_d         = aborted_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_addr_d  = first_err_addr_q;
    done              = 1'b0;

    if (mismatch) begin
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
      if (!first_err_valid_q) begin
        first_err_valid_d = 1'b1;
        first_err_addr_d  = tag_out_addr;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d           = StScan;
          ptr_d             = '0;
          aborted_d         = 1'b0;
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_addr_d  = '0;
        end
      end
      StScan: begin
        // Stolen host cycles leave the pointer where it is.
        if (issue_scan) begin
          ptr_d = ptr_q + 16'd1;
        end
        if (bus.i_abort) begin
          state_d   = StDrain;
          aborted_d = 1'b1;
        end else if (issue_scan && (ptr_q == LastAddr)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!scan_in_pipe) begin
          done    = ~aborted_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q           <= StIdle;
      ptr_q             <= '0;
      aborted_q         <= 1'b0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      last_addr_q       <= '0;
      host_rvalid_q     <= 1'b0;
      host_rdata_q      <= '0;
      tag_vld_q         <= '0;
      tag_host_q        <= '0;
      tag_addr_q        <= '{default: '0};
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      aborted_q         <= aborted_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_addr_q  <= first_err_addr_d;
      if (issue_en) begin
        last_addr_q <= issue_addr;
      end
      host_rvalid_q <= tag_out_vld & tag_out_host;
      if (tag_out_vld && tag_out_host) begin
        host_rdata_q <= bus.i_mem_data;
      end
      tag_vld_q[0]  <= issue_en;
      tag_host_q[0] <= issue_host;
      tag_addr_q[0] <= issue_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_host_q[i] <= tag_host_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
      end
    end
  end

  assign bus.o_mem_en          = issue_en;
  assign bus.o_mem_addr        = issue_en ? issue_addr : last_addr_q;
  assign bus.o_host_gnt        = issue_host;
  assign bus.o_host_rvalid     = host_rvalid_q;
  assign bus.o_host_rdata      = host_rdata_q;
  assign bus.o_busy            = (state_q != StIdle);
  assign bus.o_done            = done;
  assign bus.o_err_count       = err_count_q;
  assign bus.o_first_err_valid = first_err_valid_q;
  assign bus.o_first_err_addr  = first_err_addr_q;

endmodule

// File: tb/tb_mem_scan_arbiter.sv
// Scoreboard bench: three arbiters (16-deep lat 1, 16-deep lat 3, 65536-deep lat 2 all-faulty)
// against a behavioural memory and a queue-based reference of scan/host responses.
module tb_mem_scan_arbiter;

  typedef struct { logic [7:0] data; int cyc; } host_exp_t;
  typedef struct { logic [15:0] err; logic fev; logic [15:0] fea; int cyc; } res_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  rst_n, start, abort, hreq;
  logic [15:0] haddr [3];
  logic [2:0]  en_o, gnt_o, rv_o, done_o, busy_o, fev_o;
  logic [15:0] addr_o [3];
  logic [15:0] err_o [3];
  logic [15:0] fea_o [3];
  logic [7:0]  rd_o [3];
  logic [15:0] fault_mask [2];
  logic [7:0]  b_d0, b_d1, c_d0;

  logic [15:0] exp_addr_q [3][$];
  host_exp_t   exp_host_q [3][$];
  res_exp_t    exp_res_q [3][$];
  res_exp_t    last_ref [3];
  int n_tests = 0;
  int n_fail = 0;

  mem_scan_arbiter_if a_if ();
  mem_scan_arbiter_if b_if ();
  mem_scan_arbiter_if c_if ();

  mem_scan_arbiter #(.DEPTH(16), .RD_LAT(1), .SEED(8'hA5)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n[0]), .bus(a_if));
  mem_scan_arbiter #(.DEPTH(16), .RD_LAT(3), .SEED(8'hA5)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n[1]), .bus(b_if));
  mem_scan_arbiter #(.DEPTH(65536), .RD_LAT(2), .SEED(8'hA5)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n[2]), .bus(c_if));

  assign a_if.i_start = start[0];  assign a_if.i_abort = abort[0];
  assign a_if.i_host_req = hreq[0]; assign a_if.i_host_addr = haddr[0];
  assign b_if.i_start = start[1];  assign b_if.i_abort = abort[1];
  assign b_if.i_host_req = hreq[1]; assign b_if.i_host_addr = haddr[1];
  assign c_if.i_start = start[2];  assign c_if.i_abort = abort[2];
  assign c_if.i_host_req = hreq[2]; assign c_if.i_host_addr = haddr[2];

  assign en_o   = {c_if.o_mem_en, b_if.o_mem_en, a_if.o_mem_en};
  assign gnt_o  = {c_if.o_host_gnt, b_if.o_host_gnt, a_if.o_host_gnt};
  assign rv_o   = {c_if.o_host_rvalid, b_if.o_host_rvalid, a_if.o_host_rvalid};
  assign done_o = {c_if.o_done, b_if.o_done, a_if.o_done};
  assign busy_o = {c_if.o_busy, b_if.o_busy, a_if.o_busy};
  assign fev_o  = {c_if.o_first_err_valid, b_if.o_first_err_valid, a_if.o_first_err_valid};
  assign addr_o[0] = a_if.o_mem_addr;  assign addr_o[1] = b_if.o_mem_addr;
  assign addr_o[2] = c_if.o_mem_addr;
  assign err_o[0] = a_if.o_err_count;  assign err_o[1] = b_if.o_err_count;
  assign err_o[2] = c_if.o_err_count;
  assign fea_o[0] = a_if.o_first_err_addr;  assign fea_o[1] = b_if.o_first_err_addr;
  assign fea_o[2] = c_if.o_first_err_addr;
  assign rd_o[0] = a_if.o_host_rdata;  assign rd_o[1] = b_if.o_host_rdata;
  assign rd_o[2] = c_if.o_host_rdata;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic faulty(input int d, input logic [15:0] a);
    if (d == 2) return 1'b1;
    return (a < 16'd16) && fault_mask[d][a[3:0]];
  endfunction

  function automatic logic [7:0] mem_byte(input int d, input logic [15:0] a);
    return faulty(d, a) ? (pat(a) ^ 8'h3C) : pat(a);
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 2;
  endfunction

  function automatic int depth(input int d);
    return (d == 2) ? 65536 : 16;
  endfunction

  // Memory: data for the address presented in cycle t appears in cycle t+lat.
  always @(posedge clk) begin
    a_if.i_mem_data <= mem_byte(0, a_if.o_mem_addr);
    b_d0 <= mem_byte(1, b_if.o_mem_addr);
    b_d1 <= b_d0;
    b_if.i_mem_data <= b_d1;
    c_d0 <= mem_byte(2, c_if.o_mem_addr);
    c_if.i_mem_data <= c_d0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_one(input int d);
    host_exp_t   h;
    res_exp_t    r;
    logic [15:0] ea;
    if (rv_o[d]) begin
      if (exp_host_q[d].size() == 0) check("stray_host_rvalid", 32'(rv_o[d]), 0);
      else begin
        h = exp_host_q[d].pop_front();
        check("host_rdata", 32'(rd_o[d]), 32'(h.data));
        check("host_rvalid_cycle", cyc, h.cyc);
      end
    end
    if (gnt_o[d]) check("host_issue_addr", 32'(addr_o[d]), 32'(haddr[d]));
    if (en_o[d] && !gnt_o[d]) begin
      if (exp_addr_q[d].size() == 0) check("stray_scan_issue", 32'(en_o[d]), 0);
      else begin
        ea = exp_addr_q[d].pop_front();
        check("scan_addr", 32'(addr_o[d]), 32'(ea));
      end
    end
    if (done_o[d]) begin
      if (exp_res_q[d].size() == 0) check("stray_done", 32'(done_o[d]), 0);
      else begin
        r = exp_res_q[d].pop_front();
        check("err_count", 32'(err_o[d]), 32'(r.err));
        check("first_err_valid", 32'(fev_o[d]), 32'(r.fev));
        check("first_err_addr", 32'(fea_o[d]), 32'(r.fea));
        if (r.cyc >= 0) check("done_cycle", cyc, r.cyc);
      end
    end
  endtask

  // Reference: count faulty addresses over the sweep, saturating, and find the lowest one.
  function automatic res_exp_t scan_ref(input int d);
    res_exp_t r;
    int cnt = 0;
    r.fev = 1'b0;
    r.fea = '0;
    for (int a = 0; a < depth(d); a++) begin
      if (faulty(d, 16'(a))) begin
        cnt++;
        if (!r.fev) begin
          r.fev = 1'b1;
          r.fea = 16'(a);
        end
      end
    end
    r.err = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
    r.cyc = -1;
    return r;
  endfunction

  // stolen < 0: host traffic not known up front, so completion time is not checked.
  task automatic start_scan(input int d, input int stolen, input logic with_abort);
    res_exp_t r;
    for (int a = 0; a < depth(d); a++) exp_addr_q[d].push_back(16'(a));
    r = scan_ref(d);
    if (stolen >= 0) r.cyc = cyc + depth(d) + 1 + lat(d) + stolen;
    exp_res_q[d].push_back(r);
    last_ref[d] = r;
    start[d] = 1'b1;
    abort[d] = with_abort;
    tick();
    start[d] = 1'b0;
    abort[d] = 1'b0;
  endtask

  task automatic host_read(input int d, input logic [15:0] a);
    host_exp_t h;
    hreq[d]  = 1'b1;
    haddr[d] = a;
    #1;
    check("host_gnt", 32'(gnt_o[d]), 1);
    h.data = mem_byte(d, a);
    h.cyc  = cyc + lat(d) + 1;
    exp_host_q[d].push_back(h);
    tick();
    hreq[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while ((exp_res_q[d].size() != 0 || busy_o[d]) && n < budget) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("scan_result_missing", exp_res_q[d].size(), 0);
    check("busy_after_scan", 32'(busy_o[d]), 0);
    check("scan_addrs_unissued", exp_addr_q[d].size(), 0);
    check("host_resp_missing", exp_host_q[d].size(), 0);
    check("err_count_hold", 32'(err_o[d]), 32'(last_ref[d].err));
  endtask

  task automatic run_random(input int d, input int iters);
    for (int it = 0; it < iters; it++) begin
      fault_mask[d] = 16'($urandom);
      start_scan(d, -1, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 30; k++) begin
        if (k == 10 && busy_o[d]) begin
          start[d] = 1'b1;
          tick();
          start[d] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) host_read(d, 16'($urandom));
        else tick();
      end
      wait_idle(d, 200);
    end
  endtask

  initial begin
    int s, n;
    rst_n = '0; start = '0; abort = '0; hreq = '0;
    for (int d = 0; d < 3; d++) haddr[d] = '0;
    fault_mask[0] = '0;
    fault_mask[1] = '0;
    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) if (rst_n[d]) mon_one(d);
      end
    join_none
    repeat (3) tick();
    check("reset_busy", 32'(busy_o), 0);
    check("reset_err_a", 32'(err_o[0]), 0);
    rst_n = 3'b111;
    repeat (2) tick();
    start_scan(2, 0, 1'b0);  // long saturation sweep runs alongside everything else

    // Clean sweep, then faults at 5 and 11 with start+abort together and a restart attempt.
    for (int d = 0; d < 2; d++) begin
      fault_mask[d] = '0;
      start_scan(d, 0, 1'b0);
      wait_idle(d, 100);
      fault_mask[d] = 16'h0820;
      start_scan(d, 0, 1'b1);
      repeat (5) tick();
      start[d] = 1'b1;
      tick();
      start[d] = 1'b0;
      wait_idle(d, 100);
      fault_mask[d] = '0;
      start_scan(d, 1, 1'b0);
      repeat (7) tick();
      host_read(d, 16'h0123);  // lands on the cycle address 7 would issue
      wait_idle(d, 100);
    end

    // Abort while address 9 is being issued.
    for (int a = 0; a < 10; a++) exp_addr_q[0].push_back(16'(a));
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (9) tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    n = 0;
    while (busy_o[0] && n < 10) begin
      tick();
      n++;
    end
    check("abort_drain_within_lat", 32'(n <= lat(0) + 1), 1);
    repeat (6) tick();
    check("abort_addrs_left", 32'(exp_addr_q[0].size() <= 1), 1);
    exp_addr_q[0].delete();
    check("abort_err_count", 32'(err_o[0]), 0);

    // Reset in the middle of a sweep with reads in flight.
    fault_mask[0] = 16'hFFFF;
    start_scan(0, 0, 1'b0);
    repeat (4) tick();
    hreq[0]  = 1'b1;
    haddr[0] = 16'h0042;
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("rst_mem_en", 32'(en_o[0]), 0);
    check("rst_host_gnt", 32'(gnt_o[0]), 0);
    check("rst_busy", 32'(busy_o[0]), 0);
    check("rst_err_count", 32'(err_o[0]), 0);
    check("rst_first_err_valid", 32'(fev_o[0]), 0);
    check("rst_mem_addr", 32'(addr_o[0]), 0);
    exp_addr_q[0].delete();
    exp_host_q[0].delete();
    exp_res_q[0].delete();
    hreq[0] = 1'b0;
    repeat (3) tick();
    rst_n[0] = 1'b1;
    repeat (8) tick();
    check("post_rst_err_count", 32'(err_o[0]), 0);
    check("post_rst_first_err_valid", 32'(fev_o[0]), 0);
    check("post_rst_busy", 32'(busy_o[0]), 0);

    run_random(0, 4);
    run_random(1, 4);

    wait_idle(2, 70000);
    s = n_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, s);
    $finish;
  end

endmodule
